alu_seq: RTL and testbench

Parametrised successor to the single-cycle accumulator ALU. It executes one operation per start request on signed WIDTH-bit operands from ACC. Logic, add/sub and shift operations complete in one cycle. Multiply and divide are iterative multi-cycle operations with a start/busy/done handshake. Results are held in BR (low/quotient) and MR (high/remainder), driven onto the CPU bus under C9/C10, and summarised in a flag vector consumed by the control unit.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_muldiv.sv | 100 ++++++++++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op codes, flag indices and FSM encoding for alu_seq
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MPY = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    localparam int FLAG_ZF = 5;
    localparam int FLAG_CF = 4;
    localparam int FLAG_OF = 3;
    localparam int FLAG_NF = 2;
    localparam int FLAG_DZ = 1;
    localparam int FLAG_MF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // BR is filled with copies of this bit on divide-by-zero
    localparam logic DZ_FILL_BIT = 1'b1;

    function automatic logic is_single_cycle(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_NOT) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative magnitude shift-add multiplier / restoring divider
module alu_seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic             last,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]     mag;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic [CNT_W-1:0]     cnt;
    logic                 active;
    logic                 fix_q;
    logic                 div_q;
    logic                 neg_q;
    logic                 neg_r;

    logic [WIDTH-1:0]     abs_p;
    logic [WIDTH-1:0]     abs_q;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign abs_p = p[WIDTH-1] ? -p : p;
    assign abs_q = q[WIDTH-1] ? -q : q;

    // Multiply: acc_hi accumulates |P|, acc_lo shifts out |Q| LSB-first.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag};
    assign div_ge    = ~div_diff[WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mag    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            active <= 1'b0;
            fix_q  <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            fix_q <= 1'b0;
            if (start) begin
                mag    <= op_div ? abs_q : abs_p;
                acc_lo <= op_div ? abs_p : abs_q;
                acc_hi <= '0;
                cnt    <= CNT_W'(WIDTH - 1);
                active <= 1'b1;
                div_q  <= op_div;
                neg_q  <= p[WIDTH-1] ^ q[WIDTH-1];
                neg_r  <= p[WIDTH-1];
            end else if (active) begin
                if (div_q) begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == '0) begin
                    active <= 1'b0;
                    fix_q  <= 1'b1;
                end
            end
        end
    end

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    assign last = active && (cnt == '0);
    assign done = fix_q;
    assign hi   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo   = div_q ? quo_fix : prod_fix[WIDTH-1:0];
    // Only most-negative / -1 yields a positive quotient magnitude with the MSB set
    assign ovf  = div_q ? (~neg_q & acc_lo[WIDTH-1])
                        : (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequenced ALU: single-cycle datapath, mul/div handshake, BR/MR and flags
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SH_W          = $clog2(WIDTH),
    parameter int CLEAR_ON_READ = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_acc_alu_p,
    input  logic [WIDTH-1:0] i_acc_alu_q,
    input  logic [3:0]       ctrl_alu_op,
    input  logic             ctrl_alu_start,
    output logic             o_busy,
    output logic             o_done,
    input  logic             C9,
    input  logic             C10,
    output logic [WIDTH-1:0] o_br,
    output logic [WIDTH-1:0] o_mr,
    output logic [5:0]       o_flags,
    input  logic             i_user_sample,
    output logic [WIDTH-1:0] o_mr_user
);
    state_t           state;
    logic [WIDTH-1:0] br, mr;
    logic             zf, cf, of, nf, dz;
    logic             run_div;

    logic             launch;
    logic             eng_last, eng_done, eng_ovf;
    logic [WIDTH-1:0] eng_hi, eng_lo;

    logic [SH_W-1:0]    sh;
    logic [WIDTH:0]     add_w, sub_w, shl_w;
    logic signed [WIDTH:0] shr_w;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_cf, sc_of;

    wire [WIDTH-1:0] p = i_acc_alu_p;
    wire [WIDTH-1:0] q = i_acc_alu_q;

    assign launch = (state == ST_IDLE) && ctrl_alu_start &&
                    ((ctrl_alu_op == OP_MPY) || ((ctrl_alu_op == OP_DIV) && (q != '0)));

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .start  (launch),
        .op_div (ctrl_alu_op == OP_DIV),
        .p      (p),
        .q      (q),
        .last   (eng_last),
        .done   (eng_done),
        .hi     (eng_hi),
        .lo     (eng_lo),
        .ovf    (eng_ovf)
    );

    // Shifts widen by one bit so the last bit shifted out lands in a fixed position
    assign sh    = q[SH_W-1:0];
    assign add_w = {1'b0, p} + {1'b0, q};
    assign sub_w = {1'b0, p} - {1'b0, q};
    assign shl_w = {1'b0, p} << sh;
    assign shr_w = $signed({p, 1'b0}) >>> sh;

    always_comb begin
        sc_res = '0;
        sc_cf  = 1'b0;
        sc_of  = 1'b0;
        case (ctrl_alu_op)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_cf  = add_w[WIDTH];
                sc_of  = (p[WIDTH-1] == q[WIDTH-1]) && (add_w[WIDTH-1] != p[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_cf  = sub_w[WIDTH];
                sc_of  = (p[WIDTH-1] != q[WIDTH-1]) && (sub_w[WIDTH-1] != p[WIDTH-1]);
            end
            OP_AND: sc_res = p & q;
            OP_OR:  sc_res = p | q;
            OP_NOT: sc_res = ~q;
            OP_SHR: begin
                sc_res = shr_w[WIDTH:1];
                sc_cf  = shr_w[0];
            end
            OP_SHL: begin
                sc_res = shl_w[WIDTH-1:0];
                sc_cf  = shl_w[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            br      <= '0;
            mr      <= '0;
            {zf, cf, of, nf, dz} <= '0;
            run_div <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A commit below overrides these clears by coming later
                    if (CLEAR_ON_READ != 0) begin
                        if (C9)  br <= '0;
                        if (C10) mr <= '0;
                    end
                    if (ctrl_alu_start) begin
                        if (launch) begin
                            state   <= (ctrl_alu_op == OP_DIV) ? ST_DIV : ST_MUL;
                            run_div <= (ctrl_alu_op == OP_DIV);
                            o_busy  <= 1'b1;
                        end else if (ctrl_alu_op == OP_DIV) begin
                            br     <= {WIDTH{DZ_FILL_BIT}};
                            mr     <= p;
                            zf     <= ~DZ_FILL_BIT;
                            cf     <= 1'b0;
                            of     <= 1'b0;
                            nf     <= DZ_FILL_BIT;
                            dz     <= 1'b1;
                            o_done <= 1'b1;
                        end else if (is_single_cycle(ctrl_alu_op)) begin
                            br     <= sc_res;
                            zf     <= (sc_res == '0);
                            cf     <= sc_cf;
                            of     <= sc_of;
                            nf     <= sc_res[WIDTH-1];
                            dz     <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (eng_last) state <= ST_FIX;
                end
                ST_FIX: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                    if (eng_done) begin
                        br     <= eng_lo;
                        mr     <= eng_hi;
                        zf     <= run_div ? (eng_lo == '0) : ({eng_hi, eng_lo} == '0);
                        cf     <= 1'b0;
                        of     <= eng_ovf;
                        nf     <= run_div ? eng_lo[WIDTH-1] : eng_hi[WIDTH-1];
                        dz     <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_br      = C9 ? br : '0;
    assign o_mr      = C10 ? mr : '0;
    assign o_mr_user = i_user_sample ? mr : '0;

    always_comb begin
        o_flags          = '0;
        o_flags[FLAG_ZF] = zf;
        o_flags[FLAG_CF] = cf;
        o_flags[FLAG_OF] = of;
        o_flags[FLAG_NF] = nf;
        o_flags[FLAG_DZ] = dz;
        o_flags[FLAG_MF] = (mr != '0);
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=16)
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] p = '0, q = '0;
    logic [3:0]  op = '0;
    logic        start = 1'b0;
    logic        c9 = 1'b0, c10 = 1'b0, usr = 1'b0;
    logic        busy, done;
    logic [15:0] br_o, mr_o, mru_o;
    logic [5:0]  flags;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16), .SH_W(4), .CLEAR_ON_READ(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_acc_alu_p(p), .i_acc_alu_q(q),
        .ctrl_alu_op(op), .ctrl_alu_start(start), .o_busy(busy), .o_done(done),
        .C9(c9), .C10(c10), .o_br(br_o), .o_mr(mr_o), .o_flags(flags),
        .i_user_sample(usr), .o_mr_user(mru_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_start(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        op = o; p = a; q = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int lat);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        lat = n;
    endtask

    task automatic read_regs(output logic [15:0] b, output logic [15:0] m);
        c9 = 1'b1; c10 = 1'b1;
        #1;
        b = br_o; m = mr_o;
        c9 = 1'b0; c10 = 1'b0;
        #1;
    endtask

    initial begin
        int lat;
        int ndone;
        logic [15:0] b, m;

        c9 = 1'b1; c10 = 1'b1;
        tick(); tick();
        chk("rst_br", br_o, 16'h0000);
        chk("rst_mr", mr_o, 16'h0000);
        chk("rst_flags", flags, 6'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        c9 = 1'b0; c10 = 1'b0; rst = 1'b0;

        op_start(4'd0, 16'h7FFF, 16'h0001);
        chk("add_done", done, 1'b1);
        chk("add_busy", busy, 1'b0);
        read_regs(b, m);
        chk("add_br", b, 16'h8000);
        chk("add_flags", flags, 6'h0C);
        tick();
        chk("add_done_1cyc", done, 1'b0);

        op_start(4'd2, 16'hFFFD, 16'h0007);
        chk("mpy1_busy", busy, 1'b1);
        wait_done(0, lat);
        chk("mpy1_lat", lat, 17);
        chk("mpy1_busy_fall", busy, 1'b0);
        read_regs(b, m);
        chk("mpy1_br", b, 16'hFFEB);
        chk("mpy1_mr", m, 16'hFFFF);
        chk("mpy1_flags", flags, 6'h05);
        tick();
        chk("mpy1_done_1cyc", done, 1'b0);

        op_start(4'd2, 16'h0100, 16'h0100);
        wait_done(0, lat);
        read_regs(b, m);
        chk("mpy2_br", b, 16'h0000);
        chk("mpy2_mr", m, 16'h0001);
        chk("mpy2_flags", flags, 6'h09);

        op_start(4'd8, 16'hFFF9, 16'h0002);
        wait_done(0, lat);
        chk("div1_lat", lat, 17);
        read_regs(b, m);
        chk("div1_br", b, 16'hFFFD);
        chk("div1_mr", m, 16'hFFFF);
        chk("div1_flags", flags, 6'h05);

        op_start(4'd8, 16'h0005, 16'h0000);
        chk("dz_done", done, 1'b1);
        chk("dz_busy", busy, 1'b0);
        read_regs(b, m);
        chk("dz_br", b, 16'hFFFF);
        chk("dz_mr", m, 16'h0005);
        chk("dz_flags", flags, 6'h07);

        op_start(4'd8, 16'h8000, 16'hFFFF);
        wait_done(0, lat);
        read_regs(b, m);
        chk("dov_br", b, 16'h8000);
        chk("dov_mr", m, 16'h0000);
        chk("dov_flags", flags, 6'h0C);

        op_start(4'd7, 16'h8001, 16'h0001);
        read_regs(b, m);
        chk("shl_br", b, 16'h0002);
        chk("shl_flags", flags, 6'h10);

        op_start(4'd6, 16'h8000, 16'h000F);
        read_regs(b, m);
        chk("shr_br", b, 16'hFFFF);
        chk("shr_flags", flags, 6'h04);

        op_start(4'd7, 16'h1234, 16'h0010);
        read_regs(b, m);
        chk("sh0_br", b, 16'h1234);
        chk("sh0_flags", flags, 6'h00);

        op_start(4'd2, 16'h0003, 16'h0005);
        tick(); tick(); tick();
        op = 4'd0; p = 16'h7FFF; q = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", busy, 1'b1);
        wait_done(4, lat);
        chk("ign_lat", lat, 17);
        read_regs(b, m);
        chk("ign_br", b, 16'h000F);
        chk("ign_mr", m, 16'h0000);
        chk("ign_flags", flags, 6'h00);

        op_start(4'd2, 16'h0003, 16'h0005);
        tick(); tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        read_regs(b, m);
        chk("abort_br", b, 16'h0000);
        chk("abort_mr", m, 16'h0000);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        op_start(4'd0, 16'h0002, 16'h0003);
        c9 = 1'b1;
        #1;
        chk("rc_read", br_o, 16'h0005);
        tick();
        chk("rc_cleared", br_o, 16'h0000);
        c9 = 1'b0;

        c9 = 1'b1;
        op_start(4'd0, 16'h0004, 16'h0004);
        chk("rc_commit_wins", br_o, 16'h0008);
        c9 = 1'b0;

        op_start(4'd8, 16'h0042, 16'h0000);
        usr = 1'b1;
        #1;
        chk("usr_mr", mru_o, 16'h0042);
        tick();
        chk("usr_mr_kept", mru_o, 16'h0042);
        usr = 1'b0;
        #1;
        chk("usr_gate", mru_o, 16'h0000);

        op_start(4'd9, 16'h1111, 16'h2222);
        chk("nop_done", done, 1'b1);
        chk("nop_busy", busy, 1'b0);
        chk("nop_flags", flags, 6'h07);
        read_regs(b, m);
        chk("nop_br", b, 16'hFFFF);
        chk("nop_mr", m, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
